regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file, the successor of the single-write, dual-read CPU register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional hardwired zero register; async active-low reset clears all state.
- Integrated per-register busy scoreboard for pipelined/multi-issue cores. Sits in the decode/writeback stage of the RISC-V datapath.

Parameters:
DATA_W, 32, width of each register in bits
DEPTH, 32, number of registers (>=2, need not be a power of 2)
NUM_RD, 2, number of read ports (1..8)
NUM_WR, 2, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never busy
ADDR_W, $clog2(DEPTH), derived localparam, not overridable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  read addresses; port p at bits [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data; port p at bits [p*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  registered busy flag for each port's address
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  write addresses
wr_data  input  NUM_WR*DATA_W  write data
rsv_en  input  1  reserve request: mark a register busy
rsv_addr  input  ADDR_W  register to reserve
busy_vec  output  DEPTH  current scoreboard state, bit i = register i busy

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release on clk):
  - all DEPTH registers cleared to 0
  - rd_data = 0, rd_busy = 0, busy_vec = 0
  - Reset mid-operation discards pending writes and reservations immediately.
- Valid write: wr_en[w]=1, wr_addr[w] < DEPTH, and not (ZERO_REG=1 and wr_addr[w]=0). Invalid writes have no effect on storage, bypass or scoreboard.
- Write: each valid write updates its register at the rising edge.
- Write collision: several valid writes to the same address in one cycle resolve to the highest-index write port, for both storage and bypass.
- Read: latency 1.
  - rd_en[p]=1: rd_data[p] loads storage[rd_addr[p]] at the edge.
  - rd_en[p]=0: rd_data[p] and rd_busy[p] hold their previous values.
- Write-through bypass: if a valid write targets rd_addr[p] in the same cycle, rd_data[p] loads the winning wr_data, never the stale value.
- Out-of-range read (rd_addr >= DEPTH): rd_data loads 0 and rd_busy loads 0.
- ZERO_REG=1 and read of address 0: rd_data loads 0, rd_busy loads 0.
- Scoreboard, per register next-state:
  - rsv_en=1 with rsv_addr equal to that register: busy set to 1. This holds even if a valid write to the same register occurs in the same cycle: the new reservation supersedes the completing write.
  - Otherwise, any valid write to that register: busy cleared to 0.
  - Otherwise: busy holds.
  - Reserving register 0 when ZERO_REG=1 is ignored.
  - Out-of-range rsv_addr is ignored.
  - Re-reserving an already-busy register keeps it busy; no counting.
- rd_busy[p] loads the next-state busy bit of rd_addr[p], i.e. it includes same-edge reserve/clear, consistent with the bypass.
- busy_vec is the registered scoreboard, directly from flops.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset: write 0xDEADBEEF to x5, pulse rst_n low for 3 ns between edges -> busy_vec=0 immediately and rd_data=0; next read of x5 returns 0x00000000.
- Basic read and bypass:
  - write x7=0x12345678, read x7 next cycle -> 0x12345678 one cycle after rd_en.
  - same-cycle write x9=0xA5A5A5A5 with read of x9 on both ports -> both rd_data=0xA5A5A5A5.
- Write collision: wr port0 x3=0x1111, port1 x3=0x2222 same cycle, read x3 same cycle and next -> both reads return 0x2222.
- Zero register (ZERO_REG=1): write x0=0xFFFFFFFF, reserve x0 -> read x0=0, busy_vec[0]=0; repeat with ZERO_REG=0 -> read x0=0xFFFFFFFF.
- Scoreboard:
  - rsv x12 -> busy_vec[12]=1 next cycle; read x12 -> rd_busy=1.
  - write x12 -> busy_vec[12]=0.
  - rsv x12 and write x12 same cycle -> busy_vec[12]=1, data updated.
- Geometry and hold: DEPTH=24, NUM_RD=3, NUM_WR=1.
  - read addr 30 -> rd_data=0, rd_busy=0; write addr 30 -> no register changes.
  - rd_en[2]=0 while other ports read -> rd_data[2] holds its prior value.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, reservation request and scoreboard view.
// The core drives through the master modport; the register file sits on the slave modport.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and a per-register busy scoreboard.
// Reads return the state the register will hold after this edge, so bypass and busy agree.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam bit ZR     = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_rd_data [NUM_RD];
    logic [NUM_RD-1:0] r_rd_busy;

    logic [DATA_W-1:0] w_mem_nxt [DEPTH];
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [NUM_WR-1:0] w_wr_vld;
    logic              w_rsv_vld;
    logic [DATA_W-1:0] w_rd_data [NUM_RD];
    logic [NUM_RD-1:0] w_rd_busy;

    // In range and not the hardwired zero register
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZR && (a == '0));
    endfunction

    // Qualify write and reserve requests
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_vld[w] = bus.wr_en[w] && addr_ok(bus.wr_addr[w*ADDR_W +: ADDR_W]);
        end
        w_rsv_vld = bus.rsv_en && addr_ok(bus.rsv_addr);
    end

    // Next storage and scoreboard state; later write ports overwrite earlier ones, reserve wins last
    always_comb begin
        w_mem_nxt  = r_mem;
        w_busy_nxt = r_busy;
        for (int i = 0; i < DEPTH; i++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                w_mem_nxt[i]  = (w_wr_vld[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)))
                                ? bus.wr_data[w*DATA_W +: DATA_W] : w_mem_nxt[i];
                w_busy_nxt[i] = (w_wr_vld[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)))
                                ? 1'b0 : w_busy_nxt[i];
            end
            w_busy_nxt[i] = (w_rsv_vld && (bus.rsv_addr == ADDR_W'(i))) ? 1'b1 : w_busy_nxt[i];
        end
    end

    // Read mux over next-state; out-of-range and zero-register reads fall through to 0
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                w_rd_data[p] = ((bus.rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) && !(ZR && (i == 0)))
                               ? w_mem_nxt[i] : w_rd_data[p];
                w_rd_busy[p] = ((bus.rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) && !(ZR && (i == 0)))
                               ? w_busy_nxt[i] : w_rd_busy[p];
            end
        end
    end

    // Storage and scoreboard flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            r_mem  <= w_mem_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Read port registers, held while the port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_RD; p++) begin
                r_rd_data[p] <= '0;
            end
            r_rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rd_en[p]) begin
                    r_rd_data[p] <= w_rd_data[p];
                    r_rd_busy[p] <= w_rd_busy[p];
                end else begin
                    r_rd_data[p] <= r_rd_data[p];
                    r_rd_busy[p] <= r_rd_busy[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_out
        assign bus.rd_data[p*DATA_W +: DATA_W] = r_rd_data[p];
    end
    assign bus.rd_busy  = r_rd_busy;
    assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp: default geometry, ZERO_REG=0 variant and a 24-entry 3R/1W variant.
module tb_regfile_mp;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus_b ();
    regfile_mp_if #(.DATA_W(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(1)) bus_c ();

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_mp #(.DATA_W(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(1), .ZERO_REG(1))
        u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus_a.rd_en = '0; bus_a.rd_addr = '0; bus_a.wr_en = '0; bus_a.wr_addr = '0;
        bus_a.wr_data = '0; bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0;
        bus_b.rd_en = '0; bus_b.rd_addr = '0; bus_b.wr_en = '0; bus_b.wr_addr = '0;
        bus_b.wr_data = '0; bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0;
        bus_c.rd_en = '0; bus_c.rd_addr = '0; bus_c.wr_en = '0; bus_c.wr_addr = '0;
        bus_c.wr_data = '0; bus_c.rsv_en = 1'b0; bus_c.rsv_addr = '0;
    endtask

    // Apply the staged inputs for one edge, then sample 1 ns later with inputs cleared
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy_vec", 64'(bus_a.busy_vec), 64'h0);
        check_val("rst_rd_data", 64'(bus_a.rd_data), 64'h0);
        check_val("rst_rd_busy", 64'(bus_a.rd_busy), 64'h0);
        check_val("rst_rd_data_c", 64'(bus_c.rd_data), 64'h0);
        rst_n = 1'b1;

        // x5 = DEADBEEF and reserve it, read it back, then async reset mid-cycle
        bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd5}; bus_a.wr_data = {32'h0, 32'hDEADBEEF};
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd5;
        tick();
        check_val("pre_rst_busy5", 64'(bus_a.busy_vec), 64'h0000_0020);
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd5};
        tick();
        check_val("pre_rst_rd_x5", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_busy_vec", 64'(bus_a.busy_vec), 64'h0);
        check_val("async_rst_rd_data", 64'(bus_a.rd_data), 64'h0);
        #2;
        rst_n = 1'b1;
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd5};
        tick();
        check_val("post_rst_rd_x5", 64'(bus_a.rd_data[31:0]), 64'h0);

        // Plain write then read one cycle later
        bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd7}; bus_a.wr_data = {32'h0, 32'h12345678};
        tick();
        bus_a.rd_en = 2'b10; bus_a.rd_addr = {5'd7, 5'd0};
        tick();
        check_val("rd_x7_p1", 64'(bus_a.rd_data[63:32]), 64'h12345678);

        // Same-cycle bypass on both read ports
        bus_a.wr_en = 2'b10; bus_a.wr_addr = {5'd9, 5'd0}; bus_a.wr_data = {32'hA5A5A5A5, 32'h0};
        bus_a.rd_en = 2'b11; bus_a.rd_addr = {5'd9, 5'd9};
        tick();
        check_val("bypass_x9_p0", 64'(bus_a.rd_data[31:0]), 64'hA5A5A5A5);
        check_val("bypass_x9_p1", 64'(bus_a.rd_data[63:32]), 64'hA5A5A5A5);

        // Collision: higher write port wins for bypass and storage
        bus_a.wr_en = 2'b11; bus_a.wr_addr = {5'd3, 5'd3}; bus_a.wr_data = {32'h2222, 32'h1111};
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd3};
        tick();
        check_val("collide_bypass_x3", 64'(bus_a.rd_data[31:0]), 64'h2222);
        bus_a.rd_en = 2'b10; bus_a.rd_addr = {5'd3, 5'd0};
        tick();
        check_val("collide_store_x3", 64'(bus_a.rd_data[63:32]), 64'h2222);

        // x0: write, reserve and read in one cycle on ZERO_REG=1 and ZERO_REG=0
        bus_a.wr_en = 2'b01; bus_a.wr_addr = '0; bus_a.wr_data = {32'h0, 32'hFFFFFFFF};
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd0; bus_a.rd_en = 2'b01; bus_a.rd_addr = '0;
        bus_b.wr_en = 2'b01; bus_b.wr_addr = '0; bus_b.wr_data = {32'h0, 32'hFFFFFFFF};
        bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 5'd0; bus_b.rd_en = 2'b01; bus_b.rd_addr = '0;
        tick();
        check_val("zr1_rd_x0", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("zr1_rd_busy_x0", 64'(bus_a.rd_busy[0]), 64'h0);
        check_val("zr1_busy_vec", 64'(bus_a.busy_vec), 64'h0);
        check_val("zr0_rd_x0", 64'(bus_b.rd_data[31:0]), 64'hFFFFFFFF);
        check_val("zr0_rd_busy_x0", 64'(bus_b.rd_busy[0]), 64'h1);
        check_val("zr0_busy_vec", 64'(bus_b.busy_vec), 64'h1);
        bus_a.rd_en = 2'b01; bus_a.rd_addr = '0;
        bus_b.rd_en = 2'b01; bus_b.rd_addr = '0;
        tick();
        check_val("zr1_rd_x0_again", 64'(bus_a.rd_data[31:0]), 64'h0);
        check_val("zr0_rd_x0_again", 64'(bus_b.rd_data[31:0]), 64'hFFFFFFFF);

        // Scoreboard on x12: reserve, observe, clear by write, reserve-and-write
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd12;
        tick();
        check_val("rsv_x12_vec", 64'(bus_a.busy_vec), 64'h0000_1000);
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd12};
        tick();
        check_val("rsv_x12_rd_busy", 64'(bus_a.rd_busy[0]), 64'h1);
        bus_a.wr_en = 2'b10; bus_a.wr_addr = {5'd12, 5'd0}; bus_a.wr_data = {32'h00C0FFEE, 32'h0};
        bus_a.rd_en = 2'b10; bus_a.rd_addr = {5'd12, 5'd0};
        tick();
        check_val("clr_x12_vec", 64'(bus_a.busy_vec), 64'h0);
        check_val("clr_x12_rd_busy", 64'(bus_a.rd_busy[1]), 64'h0);
        check_val("clr_x12_rd_data", 64'(bus_a.rd_data[63:32]), 64'h00C0FFEE);
        bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd12;
        bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd12}; bus_a.wr_data = {32'h0, 32'hBEEF0012};
        bus_a.rd_en = 2'b10; bus_a.rd_addr = {5'd12, 5'd0};
        tick();
        check_val("rsvwr_x12_vec", 64'(bus_a.busy_vec), 64'h0000_1000);
        check_val("rsvwr_x12_rd_busy", 64'(bus_a.rd_busy[1]), 64'h1);
        check_val("rsvwr_x12_bypass", 64'(bus_a.rd_data[63:32]), 64'hBEEF0012);
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd12};
        tick();
        check_val("rsvwr_x12_store", 64'(bus_a.rd_data[31:0]), 64'hBEEF0012);

        // 24-entry, 3-read geometry: out-of-range access and read-port hold
        bus_c.wr_en = 1'b1; bus_c.wr_addr = 5'd4; bus_c.wr_data = 32'h44444444;
        tick();
        bus_c.rd_en = 3'b111; bus_c.rd_addr = {5'd4, 5'd4, 5'd4};
        tick();
        check_val("geo_rd_x4_p2", 64'(bus_c.rd_data[95:64]), 64'h44444444);
        check_val("geo_rd_x4_p0", 64'(bus_c.rd_data[31:0]), 64'h44444444);
        bus_c.wr_en = 1'b1; bus_c.wr_addr = 5'd30; bus_c.wr_data = 32'h30303030;
        bus_c.rsv_en = 1'b1; bus_c.rsv_addr = 5'd30;
        bus_c.rd_en = 3'b011; bus_c.rd_addr = {5'd0, 5'd4, 5'd30};
        tick();
        check_val("geo_oor_rd_data", 64'(bus_c.rd_data[31:0]), 64'h0);
        check_val("geo_oor_rd_busy", 64'(bus_c.rd_busy[0]), 64'h0);
        check_val("geo_rd_x4_p1", 64'(bus_c.rd_data[63:32]), 64'h44444444);
        check_val("geo_hold_p2", 64'(bus_c.rd_data[95:64]), 64'h44444444);
        check_val("geo_oor_busy_vec", 64'(bus_c.busy_vec), 64'h0);
        bus_c.rd_en = 3'b111; bus_c.rd_addr = {5'd22, 5'd14, 5'd6};
        tick();
        check_val("geo_oor_wr_alias", 64'(bus_c.rd_data), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
